// File: rtl/shift_right_sipo_rx.sv
// LSB-first serial-to-parallel receiver with a one-word valid/ready output buffer.
// Latency: word visible the cycle after its last bit is accepted; all outputs registered.
// Backpressure: serial side never stalls; a word completing into a full, unconsumed buffer is dropped and flags overrun.
module shift_right_sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     serial_valid,
  input  logic                     serial_data_in,
  input  logic                     sync,
  input  logic                     data_ready,
  input  logic                     clr_overrun,
  output logic [WIDTH-1:0]         parallel_data_out,
  output logic                     data_valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_nxt;
  logic             last_bit;
  logic             word_done;
  logic             xfer;
  logic             word_drop;

  assign shift_nxt = {serial_data_in, shreg[WIDTH-1:1]};
  assign last_bit  = (bit_count == CW'(WIDTH - 1));
  // A sync bit always restarts at bit 0, so it can never finish a word.
  assign word_done = serial_valid && !sync && last_bit;
  assign xfer      = data_valid && data_ready;
  assign word_drop = word_done && data_valid && !data_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg             <= '0;
      bit_count         <= '0;
      parallel_data_out <= '0;
      data_valid        <= 1'b0;
      overrun           <= 1'b0;
    end else begin
      if (serial_valid) begin
        shreg <= shift_nxt;
        if (sync)
          bit_count <= CW'(1);
        else if (last_bit)
          bit_count <= '0;
        else
          bit_count <= bit_count + CW'(1);
      end else if (sync) begin
        bit_count <= '0;
      end

      if (word_done && (!data_valid || xfer)) begin
        parallel_data_out <= shift_nxt;
        data_valid        <= 1'b1;
      end else if (xfer) begin
        data_valid <= 1'b0;
      end

      // A drop in the same cycle as a clear must still be reported.
      if (word_drop)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_right_sipo_rx.sv
// Bench for shift_right_sipo_rx (WIDTH=4): directed vector table, PISO pairing, randomized model compare.
module tb_shift_right_sipo_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         serial_valid = 1'b0;
  logic         serial_data_in = 1'b0;
  logic         sync = 1'b0;
  logic         data_ready = 1'b0;
  logic         clr_overrun = 1'b0;
  logic [W-1:0] parallel_data_out;
  logic         data_valid;
  logic         overrun;
  logic [1:0]   bit_count;

  int checks = 0;
  int errors = 0;

  shift_right_sipo_rx #(.WIDTH(W)) dut (
    .clk               (clk),
    .reset             (reset),
    .serial_valid      (serial_valid),
    .serial_data_in    (serial_data_in),
    .sync              (sync),
    .data_ready        (data_ready),
    .clr_overrun       (clr_overrun),
    .parallel_data_out (parallel_data_out),
    .data_valid        (data_valid),
    .overrun           (overrun),
    .bit_count         (bit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, v, d, s, rdy, clr;
    logic [3:0] e_dat;
    logic       e_vld, e_ovr;
    logic [1:0] e_cnt;
    logic       chk_dat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, v, d, s, rdy, clr,
                              input logic [3:0] e_dat, input logic e_vld, e_ovr,
                              input logic [1:0] e_cnt, input logic chk_dat);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.s = s; x.rdy = rdy; x.clr = clr;
    x.e_dat = e_dat; x.e_vld = e_vld; x.e_ovr = e_ovr; x.e_cnt = e_cnt; x.chk_dat = chk_dat;
    tbl.push_back(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs just after an edge, let the next edge capture them, sample 1 time unit later.
  task automatic drive(input logic r, v, d, s, rdy, clr);
    reset = r; serial_valid = v; serial_data_in = d; sync = s; data_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model state: partial bits as a list, output buffer as plain values.
  bit       m_bits[$];
  bit [3:0] m_dat;
  bit       m_vld, m_ovr;

  function automatic void model_step(input bit r, v, d, s, rdy, clr);
    bit       xfer, done, drop;
    bit [3:0] word;
    if (!r) begin
      m_bits.delete(); m_dat = 0; m_vld = 0; m_ovr = 0;
      return;
    end
    xfer = m_vld && rdy;
    done = 0; drop = 0; word = 0;
    if (s) m_bits.delete();
    if (v) begin
      m_bits.push_back(d);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) word += 4'(m_bits[i]) << i;
        m_bits.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_vld || xfer) begin m_dat = word; m_vld = 1; end
      else drop = 1;
    end else if (xfer) begin
      m_vld = 0;
    end
    if (drop) m_ovr = 1;
    else if (clr) m_ovr = 0;
  endfunction

  initial begin
    //   r v d s rdy clr  dat     vld ovr cnt chk
    add(0,0,0,0,0,0, 4'b0000, 0,0,0, 1);  // reset
    // basic word 0,1,0,1 -> 1010, then consume
    add(1,1,0,0,0,0, 4'b0000, 0,0,1, 0);
    add(1,1,1,0,0,0, 4'b0000, 0,0,2, 0);
    add(1,1,0,0,0,0, 4'b0000, 0,0,3, 0);
    add(1,1,1,0,0,0, 4'b1010, 1,0,0, 1);
    add(1,0,0,0,1,0, 4'b0000, 0,0,0, 0);
    // back-to-back: 0011 then 1100 loaded on the transfer cycle, no bubble
    add(1,1,1,0,1,0, 4'b0000, 0,0,1, 0);
    add(1,1,1,0,1,0, 4'b0000, 0,0,2, 0);
    add(1,1,0,0,1,0, 4'b0000, 0,0,3, 0);
    add(1,1,0,0,0,0, 4'b0011, 1,0,0, 1);
    add(1,1,0,0,0,0, 4'b0011, 1,0,1, 1);
    add(1,1,0,0,0,0, 4'b0011, 1,0,2, 1);
    add(1,1,1,0,0,0, 4'b0011, 1,0,3, 1);
    add(1,1,1,0,1,0, 4'b1100, 1,0,0, 1);
    add(1,0,0,0,1,0, 4'b0000, 0,0,0, 0);
    // overrun: 0101 held, 1111 dropped
    add(1,1,1,0,0,0, 4'b0000, 0,0,1, 0);
    add(1,1,0,0,0,0, 4'b0000, 0,0,2, 0);
    add(1,1,1,0,0,0, 4'b0000, 0,0,3, 0);
    add(1,1,0,0,0,0, 4'b0101, 1,0,0, 1);
    add(1,1,1,0,0,0, 4'b0101, 1,0,1, 1);
    add(1,1,1,0,0,0, 4'b0101, 1,0,2, 1);
    add(1,1,1,0,0,0, 4'b0101, 1,0,3, 1);
    add(1,1,1,0,0,0, 4'b0101, 1,1,0, 1);
    add(1,0,0,0,0,1, 4'b0101, 1,0,0, 1);
    // drop and clear in the same cycle: set wins
    add(1,1,0,0,0,0, 4'b0101, 1,0,1, 1);
    add(1,1,0,0,0,0, 4'b0101, 1,0,2, 1);
    add(1,1,0,0,0,0, 4'b0101, 1,0,3, 1);
    add(1,1,0,0,0,1, 4'b0101, 1,1,0, 1);
    add(1,0,0,0,0,1, 4'b0101, 1,0,0, 1);
    add(1,0,0,0,1,0, 4'b0000, 0,0,0, 0);
    // resync: 1,1 discarded, sync bit 1 then 0,0,0 -> 0001
    add(1,1,1,0,0,0, 4'b0000, 0,0,1, 0);
    add(1,1,1,0,0,0, 4'b0000, 0,0,2, 0);
    add(1,1,1,1,0,0, 4'b0000, 0,0,1, 0);
    add(1,1,0,0,0,0, 4'b0000, 0,0,2, 0);
    add(1,1,0,0,0,0, 4'b0000, 0,0,3, 0);
    add(1,1,0,0,0,0, 4'b0001, 1,0,0, 1);
    // sync without a bit clears the count, buffer untouched
    add(1,1,1,0,1,0, 4'b0000, 0,0,1, 0);
    add(1,0,0,1,0,0, 4'b0000, 0,0,0, 0);
    // reset mid-word with valid and overrun set
    add(1,1,0,0,0,0, 4'b0000, 0,0,1, 0);
    add(1,1,1,0,0,0, 4'b0000, 0,0,2, 0);
    add(1,1,1,0,0,0, 4'b0000, 0,0,3, 0);
    add(1,1,0,0,0,0, 4'b0110, 1,0,0, 1);
    add(1,1,1,0,0,0, 4'b0110, 1,0,1, 1);
    add(1,1,1,0,0,0, 4'b0110, 1,0,2, 1);
    add(1,1,1,0,0,0, 4'b0110, 1,0,3, 1);
    add(1,1,1,0,0,0, 4'b0110, 1,1,0, 1);
    add(1,1,1,0,0,0, 4'b0110, 1,1,1, 1);
    add(1,1,0,0,0,0, 4'b0110, 1,1,2, 1);
    add(0,1,1,0,1,0, 4'b0000, 0,0,0, 1);
    add(1,1,1,0,0,0, 4'b0000, 0,0,1, 0);
    add(1,1,1,0,0,0, 4'b0000, 0,0,2, 0);
    add(1,1,1,0,0,0, 4'b0000, 0,0,3, 0);
    add(1,1,0,0,0,0, 4'b0111, 1,0,0, 1);

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].rdy, tbl[i].clr);
      check($sformatf("row%0d data_valid", i), 32'(data_valid), 32'(tbl[i].e_vld));
      check($sformatf("row%0d overrun", i),    32'(overrun),    32'(tbl[i].e_ovr));
      check($sformatf("row%0d bit_count", i),  32'(bit_count),  32'(tbl[i].e_cnt));
      if (tbl[i].chk_dat)
        check($sformatf("row%0d data", i), 32'(parallel_data_out), 32'(tbl[i].e_dat));
    end

    // PISO pairing: emulate a shift-right PISO loaded with 1010, shifting LSB first
    begin
      logic [3:0] piso;
      drive(0,0,0,0,0,0);
      piso = 4'b1010;
      for (int k = 0; k < W; k++) begin
        drive(1, 1, piso[0], 0, 0, 0);
        piso = piso >> 1;
      end
      check("piso data", 32'(parallel_data_out), 32'h0000000a);
      check("piso valid", 32'(data_valid), 32'd1);
      check("piso count", 32'(bit_count), 32'd0);
    end

    // Randomized run against the list-based model
    drive(0,0,0,0,0,0);
    model_step(0,0,0,0,0,0);
    for (int n = 0; n < 3000; n++) begin
      bit r, v, d, s, rdy, clr;
      r   = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 3) != 0);
      d   = 1'($urandom);
      s   = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      model_step(r, v, d, s, rdy, clr);
      drive(r, v, d, s, rdy, clr);
      check($sformatf("rand%0d data_valid", n), 32'(data_valid), 32'(m_vld));
      check($sformatf("rand%0d overrun", n),    32'(overrun),    32'(m_ovr));
      check($sformatf("rand%0d bit_count", n),  32'(bit_count),  32'(m_bits.size()));
      if (m_vld)
        check($sformatf("rand%0d data", n), 32'(parallel_data_out), 32'(m_dat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
